timer_array: RTL and testbench

Parametrised multi-channel down-counting timer for the system bus, successor to the single dual-8/16-bit timer. It provides NUM_CH independent channels, each with a configurable counter width, a selectable main-clock or RTC time base, and auto-reload or one-shot mode. Each channel raises underflow and compare-match interrupts through per-channel pending and enable bits. It sits on the CPU register bus beside the IRQ controller, which consumes one level-sensitive request per channel.

---
 rtl/timer_array.sv | 96 +++++++++
 tb/tb_timer_array.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/timer_array.sv
// timer_array: multi-channel down-counting timer with shared main/RTC prescalers,
// auto-reload or one-shot modes and per-channel underflow/compare interrupts.
module timer_array #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h2030
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_ce,
    input  logic              rt_tick,
    input  logic              bus_write,
    input  logic [23:0]       bus_address_in,
    input  logic [7:0]        bus_data_in,
    output logic [7:0]        bus_data_out,
    output logic [NUM_CH-1:0] irq
);
    localparam int K [8] = '{1, 3, 5, 6, 7, 8, 10, 12};
    logic [11:0]          r_main_div;
    logic [6:0]           r_rtc_div;
    logic [7:0]           w_main_hit, w_rtc_hit;
    logic [23:0]          w_off;
    logic                 w_in_range, w_we;
    logic [2:0]           w_ch, w_reg;
    logic [7:0][7:0][7:0] w_regs;
    assign w_off        = bus_address_in - BASE_ADDR;
    assign w_in_range   = w_off < 24'(8 * NUM_CH);
    assign w_ch         = w_off[5:3];
    assign w_reg        = w_off[2:0];
    assign w_we         = bus_write & clk_ce & w_in_range;
    assign bus_data_out = w_in_range ? w_regs[w_ch][w_reg] : 8'h00;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_div <= '0;
            r_rtc_div  <= '0;
        end else if (clk_ce) begin
            r_main_div <= r_main_div + 12'd1;
            r_rtc_div  <= r_rtc_div + 7'(rt_tick);
        end
    end
    // Prescaler taps are judged on the divider value before this cycle's increment.
    for (genvar p = 0; p < 8; p++) begin : g_hit
        localparam logic [11:0] MM = 12'((1 << K[p]) - 1);
        localparam logic [6:0]  RM = 7'((1 << p) - 1);
        assign w_main_hit[p] = (r_main_div & MM) == MM;
        assign w_rtc_hit[p]  = rt_tick && (r_rtc_div & RM) == RM;
    end
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic             r_en, r_os, r_src, r_ufp, r_cmpp, r_ufe, r_cmpe;
            logic [2:0]       r_psel;
            logic [CNT_W-1:0] r_cnt, r_pre, r_cmp, w_pre_nx, w_cmp_nx;
            logic [15:0]      w_p16, w_c16;
            logic             w_wr, w_ctrl_wr, w_stat_wr, w_strobe, w_tick, w_uf, w_cm;
            assign w_wr      = w_we && w_ch == 3'(c);
            assign w_ctrl_wr = w_wr && w_reg == 3'd0;
            assign w_stat_wr = w_wr && w_reg == 3'd1;
            assign w_p16     = 16'(r_pre);
            assign w_c16     = 16'(r_cmp);
            assign w_pre_nx  = CNT_W'({w_wr && w_reg == 3'd5 ? bus_data_in : w_p16[15:8],
                                       w_wr && w_reg == 3'd4 ? bus_data_in : w_p16[7:0]});
            assign w_cmp_nx  = CNT_W'({w_wr && w_reg == 3'd7 ? bus_data_in : w_c16[15:8],
                                       w_wr && w_reg == 3'd6 ? bus_data_in : w_c16[7:0]});
            assign w_strobe  = w_ctrl_wr && bus_data_in[1];
            // A load or a disabling CTRL write swallows the tick entirely.
            assign w_tick    = r_en && (r_src ? w_rtc_hit[r_psel] : w_main_hit[r_psel])
                               && !w_strobe && !(w_ctrl_wr && !bus_data_in[0]);
            assign w_uf      = w_tick && r_cnt == '0;
            assign w_cm      = w_tick && r_cnt == r_cmp;
            assign irq[c]    = (r_ufp & r_ufe) | (r_cmpp & r_cmpe);
            assign w_regs[c] = {w_c16, w_p16, 16'(r_cnt),
                                {2'b0, r_cmpe, r_ufe, 2'b0, r_cmpp, r_ufp},
                                {1'b0, r_psel, r_src, r_os, 1'b0, r_en}};
            always_ff @(posedge clk) begin
                if (reset) begin
                    {r_en, r_os, r_src, r_psel, r_ufp, r_cmpp, r_ufe, r_cmpe} <= '0;
                    r_cnt <= '0;
                    r_pre <= '0;
                    r_cmp <= '0;
                end else if (clk_ce) begin
                    r_pre  <= w_pre_nx;
                    r_cmp  <= w_cmp_nx;
                    r_cnt  <= w_strobe ? w_pre_nx : !w_tick ? r_cnt :
                              w_uf ? (r_os ? r_cnt : w_pre_nx) : r_cnt - CNT_W'(1);
                    r_en   <= !(w_uf && r_os) && (w_ctrl_wr ? bus_data_in[0] : r_en);
                    r_ufp  <= w_uf || (r_ufp && !(w_stat_wr && bus_data_in[0]));
                    r_cmpp <= w_cm || (r_cmpp && !(w_stat_wr && bus_data_in[1]));
                    if (w_ctrl_wr) {r_psel, r_src, r_os} <= bus_data_in[6:2];
                    if (w_stat_wr) {r_cmpe, r_ufe} <= bus_data_in[5:4];
                end
            end
        end else begin : g_off
            assign w_regs[c] = '0;
        end
    end
endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: random bus traffic and time-base strobes checked against an
// arithmetic reference model of every channel's registers and irq.
module tb_timer_array;
    localparam int          NCH  = 4;
    localparam int          CW   = 12;
    localparam int          MODV = 1 << CW;
    localparam logic [23:0] BASE = 24'h2030;
    localparam int          KT [8] = '{1, 3, 5, 6, 7, 8, 10, 12};
    logic           clk = 0;
    logic           reset, clk_ce, rt_tick, bus_write;
    logic [23:0]    bus_address_in;
    logic [7:0]     bus_data_in, bus_data_out;
    logic [NCH-1:0] irq;
    int m_cnt [NCH], m_pre [NCH], m_cmp [NCH], m_psel [NCH];
    bit m_en [NCH], m_os [NCH], m_src [NCH], m_ufp [NCH], m_cmpp [NCH], m_ufe [NCH], m_cmpe [NCH];
    int m_main, m_rtc;
    int total = 0, bad = 0;
    timer_array #(.NUM_CH(NCH), .CNT_W(CW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .rt_tick(rt_tick),
        .bus_write(bus_write), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        if (obs != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h addr=%h t=%0t", tag, obs, exp_v, bus_address_in, $time);
        end
    endtask
    function automatic int exp_read(input logic [23:0] a);
        int off = int'(a) - int'(BASE);
        int ch, r;
        if (off < 0 || off >= 8 * NCH) return 0;
        ch = off / 8;
        r  = off % 8;
        case (r)
            0: return int'(m_en[ch]) + 4 * int'(m_os[ch]) + 8 * int'(m_src[ch]) + 16 * m_psel[ch];
            1: return int'(m_ufp[ch]) + 2 * int'(m_cmpp[ch]) + 16 * int'(m_ufe[ch]) + 32 * int'(m_cmpe[ch]);
            2: return m_cnt[ch] % 256;
            3: return m_cnt[ch] / 256;
            4: return m_pre[ch] % 256;
            5: return m_pre[ch] / 256;
            6: return m_cmp[ch] % 256;
            default: return m_cmp[ch] / 256;
        endcase
    endfunction
    function automatic int exp_irq();
        int v = 0;
        for (int c = 0; c < NCH; c++)
            if ((m_ufp[c] && m_ufe[c]) || (m_cmpp[c] && m_cmpe[c])) v += 1 << c;
        return v;
    endfunction
    function automatic bit time_hit(input int c);
        int div = 1 << (m_src[c] ? m_psel[c] : KT[m_psel[c]]);
        if (m_src[c]) return rt_tick && (m_rtc % div == div - 1);
        return m_main % div == div - 1;
    endfunction
    task automatic model_reset();
        m_main = 0;
        m_rtc  = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_pre[c] = 0; m_cmp[c] = 0; m_psel[c] = 0;
            m_en[c] = 0; m_os[c] = 0; m_src[c] = 0;
            m_ufp[c] = 0; m_cmpp[c] = 0; m_ufe[c] = 0; m_cmpe[c] = 0;
        end
    endtask
    task automatic model_step();
        int off = int'(bus_address_in) - int'(BASE);
        logic [7:0] d = bus_data_in;
        if (reset) begin
            model_reset();
            return;
        end
        if (!clk_ce) return;
        for (int c = 0; c < NCH; c++) begin
            bit wr = bus_write && off >= 0 && off < 8 * NCH && off / 8 == c;
            int r = off % 8;
            int npre = m_pre[c], ncmp = m_cmp[c];
            bit strobe, tick, uf = 0, cm = 0, old_os = m_os[c];
            if (wr && r == 4) npre = (npre & 'hFF00) | int'(d);
            if (wr && r == 5) npre = (npre & 'h00FF) | (int'(d) << 8);
            if (wr && r == 6) ncmp = (ncmp & 'hFF00) | int'(d);
            if (wr && r == 7) ncmp = (ncmp & 'h00FF) | (int'(d) << 8);
            npre %= MODV;
            ncmp %= MODV;
            strobe = wr && r == 0 && d[1];
            tick = m_en[c] && time_hit(c) && !strobe && !(wr && r == 0 && !d[0]);
            if (strobe) m_cnt[c] = npre;
            else if (tick) begin
                cm = m_cnt[c] == m_cmp[c];
                if (m_cnt[c] == 0) begin
                    uf = 1;
                    if (!old_os) m_cnt[c] = npre;
                end else m_cnt[c] = m_cnt[c] - 1;
            end
            if (wr && r == 1) begin
                if (d[0]) m_ufp[c] = 0;
                if (d[1]) m_cmpp[c] = 0;
                m_ufe[c]  = d[4];
                m_cmpe[c] = d[5];
            end
            if (uf) m_ufp[c] = 1;
            if (cm) m_cmpp[c] = 1;
            if (wr && r == 0) begin
                m_en[c] = d[0]; m_os[c] = d[2]; m_src[c] = d[3]; m_psel[c] = int'(d[6:4]);
            end
            if (uf && old_os) m_en[c] = 0;
            m_pre[c] = npre;
            m_cmp[c] = ncmp;
        end
        m_main = (m_main + 1) % 4096;
        if (rt_tick) m_rtc = (m_rtc + 1) % 128;
    endtask
    task automatic step();
        @(negedge clk);
        check("read", int'(bus_data_out), exp_read(bus_address_in));
        check("irq", int'(irq), exp_irq());
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic drive(input bit we, input logic [23:0] a, input logic [7:0] d);
        bus_write      = we;
        bus_address_in = a;
        bus_data_in    = d;
        step();
    endtask
    function automatic logic [7:0] rand_data(input int r);
        logic [7:0] d = 8'($urandom);
        case (r)
            0: begin
                d[0] = $urandom_range(0, 3) != 0;
                d[1] = $urandom_range(0, 2) == 0;
                d[2] = $urandom_range(0, 2) == 0;
                d[3] = $urandom_range(0, 2) == 0;
                d[6:4] = $urandom_range(0, 3) != 0 ? 3'($urandom_range(0, 2)) : 3'($urandom);
            end
            3, 5, 7: if ($urandom_range(0, 3) != 0) d = 8'h00;
            4, 6: if ($urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 15));
            default: ;
        endcase
        return d;
    endfunction
    initial begin
        reset = 1; clk_ce = 1; rt_tick = 0;
        bus_write = 0; bus_address_in = BASE; bus_data_in = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 0;
        for (int a = -2; a < 8 * NCH + 2; a++) drive(0, 24'(int'(BASE) + a), 8'h00);
        drive(1, BASE + 24'd5, 8'hFF);
        drive(0, BASE + 24'd5, 8'h00);
        drive(1, BASE + 24'd7, 8'hFF);
        drive(0, BASE + 24'd7, 8'h00);
        for (int i = 0; i < 30000; i++) begin
            int ch = $urandom_range(0, NCH - 1);
            int r  = $urandom_range(0, 7);
            logic [23:0] a = BASE + 24'(8 * ch + r);
            if ($urandom_range(0, 19) == 0)
                a = $urandom_range(0, 1) ? BASE - 24'($urandom_range(1, 4))
                                         : BASE + 24'(8 * NCH + $urandom_range(0, 3));
            reset   = $urandom_range(0, 2999) == 0;
            clk_ce  = $urandom_range(0, 9) < 8;
            rt_tick = $urandom_range(0, 9) < 3;
            drive($urandom_range(0, 99) < 12, a, rand_data(r));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
